// File: rtl/axis_if.sv
// AXI-Stream bundle shared by the ingress FIFO ports and its testbench.
//   tvalid/tready : beat handshake
//   tdata         : payload, DATA_WIDTH bits
//   tkeep         : byte enables, DATA_WIDTH/8 bits
//   tlast         : end of packet
//   tuser         : sideband, USER_WIDTH bits
// The master modport drives the beat and samples tready; the slave modport is its mirror.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 128
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axis_ingress_fifo.sv
// AXI-Stream ingress buffer for the packet parser front end.
// Beats are stored in a DEPTH-entry FIFO and leave first-word fall-through, either
// cut-through (STORE_FWD = 0) or once a whole packet is buffered (STORE_FWD = 1).
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis        : AXI-Stream slave (input beats); tready is registered
//   m_axis        : AXI-Stream master (head-of-FIFO beat)
//   fill_level    : entries stored
//   pkt_count     : complete packets (tlast stored) in the FIFO
//   oversize_err  : sticky, a packet overflowed the FIFO in store-and-forward mode
module axis_ingress_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 128,
  parameter int unsigned DEPTH      = 16,
  parameter bit          STORE_FWD  = 1'b0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_if.slave                  s_axis,
  axis_if.master                 m_axis,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   oversize_err
);

  localparam int unsigned KeepW  = DATA_WIDTH / 8;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned EntryW = 1 + KeepW + USER_WIDTH + DATA_WIDTH;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t pkt_q, pkt_d;
  logic s_tready_q, s_tready_d;
  logic fwd_force_q, fwd_force_d;
  logic oversize_q, oversize_d;

  // Entry layout: {tlast, tkeep, tuser, tdata}
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] head;
  logic              head_last;
  logic              m_tvalid;
  logic              push;
  logic              pop;
  logic              stall_full;

  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[EntryW-1];

  always_comb begin
    m_tvalid = (count_q != '0) && (!STORE_FWD || (pkt_q != '0) || fwd_force_q);
  end

  assign push = s_axis.tvalid & s_tready_q;
  assign pop  = m_tvalid & m_axis.tready;

  // Full with no complete packet: in store-and-forward this can only drain if we
  // release the partial packet, otherwise the FIFO deadlocks.
  assign stall_full = (count_q == cnt_t'(DEPTH)) && (pkt_q == '0);

  always_comb begin
    count_d     = count_q + cnt_t'(push) - cnt_t'(pop);
    pkt_d       = pkt_q + cnt_t'(push & s_axis.tlast) - cnt_t'(pop & head_last);
    wr_ptr_d    = wr_ptr_q + ptr_t'(push);
    rd_ptr_d    = rd_ptr_q + ptr_t'(pop);
    s_tready_d  = (count_d != cnt_t'(DEPTH));
    fwd_force_d = fwd_force_q;
    oversize_d  = oversize_q;
    if (pop && head_last) begin
      fwd_force_d = 1'b0;
    end
    if (STORE_FWD && stall_full) begin
      fwd_force_d = 1'b1;
      oversize_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_q       <= '0;
      s_tready_q  <= 1'b0;
      fwd_force_q <= 1'b0;
      oversize_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_q       <= pkt_d;
      s_tready_q  <= s_tready_d;
      fwd_force_q <= fwd_force_d;
      oversize_q  <= oversize_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tkeep, s_axis.tuser, s_axis.tdata};
    end
  end

  always_comb begin
    s_axis.tready = s_tready_q;
    m_axis.tvalid = m_tvalid;
    m_axis.tlast  = head_last;
    m_axis.tkeep  = head[EntryW-2 -: KeepW];
    m_axis.tuser  = head[DATA_WIDTH +: USER_WIDTH];
    m_axis.tdata  = head[DATA_WIDTH-1:0];
  end

  assign fill_level   = count_q;
  assign pkt_count    = pkt_q;
  assign oversize_err = oversize_q;

endmodule

// File: tb/tb_axis_ingress_fifo.sv
// Scoreboard bench: one cut-through and one store-and-forward instance.
module tb_axis_ingress_fifo;

  typedef logic [200:0] ent_t;  // {tlast, tkeep[7:0], tuser[127:0], tdata[63:0]}

  logic aclk;
  logic aresetn;
  logic [4:0] ct_fill, ct_pkt, sf_fill, sf_pkt;
  logic ct_ovf, sf_ovf;

  int total = 0;
  int bad   = 0;
  ent_t exp_ct[$];
  ent_t exp_sf[$];

  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(128)) ct_s ();
  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(128)) ct_m ();
  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(128)) sf_s ();
  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(128)) sf_m ();

  axis_ingress_fifo #(
    .DATA_WIDTH(64), .USER_WIDTH(128), .DEPTH(16), .STORE_FWD(1'b0)
  ) dut_ct (
    .aclk(aclk), .aresetn(aresetn), .s_axis(ct_s), .m_axis(ct_m),
    .fill_level(ct_fill), .pkt_count(ct_pkt), .oversize_err(ct_ovf)
  );

  axis_ingress_fifo #(
    .DATA_WIDTH(64), .USER_WIDTH(128), .DEPTH(16), .STORE_FWD(1'b1)
  ) dut_sf (
    .aclk(aclk), .aresetn(aresetn), .s_axis(sf_s), .m_axis(sf_m),
    .fill_level(sf_fill), .pkt_count(sf_pkt), .oversize_err(sf_ovf)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic ent_t mk(input logic [63:0] d, input logic l);
    return {l, d[7:0], d, ~d, d};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge aclk) begin : mon_ct
    ent_t a;
    if (ct_m.tvalid && ct_m.tready) begin
      a = {ct_m.tlast, ct_m.tkeep, ct_m.tuser, ct_m.tdata};
      if (exp_ct.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ct_unexpected_beat got=%0h required=none", a);
      end else begin
        chk("ct_beat", a, exp_ct.pop_front());
      end
    end
  end

  always @(negedge aclk) begin : mon_sf
    ent_t a;
    if (sf_m.tvalid && sf_m.tready) begin
      a = {sf_m.tlast, sf_m.tkeep, sf_m.tuser, sf_m.tdata};
      if (exp_sf.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sf_unexpected_beat got=%0h required=none", a);
      end else begin
        chk("sf_beat", a, exp_sf.pop_front());
      end
    end
  end

  // Offer one beat; returns at #1 after the edge that accepted it.
  task automatic send(input bit sf, input logic [63:0] d, input logic l);
    bit done;
    done = 1'b0;
    if (sf) begin
      sf_s.tvalid = 1'b1; sf_s.tdata = d; sf_s.tkeep = d[7:0]; sf_s.tuser = {d, ~d};
      sf_s.tlast = l;
    end else begin
      ct_s.tvalid = 1'b1; ct_s.tdata = d; ct_s.tkeep = d[7:0]; ct_s.tuser = {d, ~d};
      ct_s.tlast = l;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (sf ? sf_s.tready : ct_s.tready) begin
        @(posedge aclk);
        #1;
        done = 1'b1;
      end
    end
    if (sf) sf_s.tvalid = 1'b0;
    else    ct_s.tvalid = 1'b0;
    if (done) begin
      if (sf) exp_sf.push_back(mk(d, l));
      else    exp_ct.push_back(mk(d, l));
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stalled required=accepted data=%0h", d);
    end
  endtask

  task automatic wait_empty(input bit sf);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      if ((sf ? sf_fill : ct_fill) == 5'd0) done = 1'b1;
    end
    @(posedge aclk);
    #1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got=nonempty required=empty sf=%0d", sf);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    ct_s.tvalid = 1'b0; ct_s.tdata = '0; ct_s.tkeep = '0; ct_s.tlast = 1'b0; ct_s.tuser = '0;
    sf_s.tvalid = 1'b0; sf_s.tdata = '0; sf_s.tkeep = '0; sf_s.tlast = 1'b0; sf_s.tuser = '0;
    ct_m.tready = 1'b0;
    sf_m.tready = 1'b0;

    // Reset state
    #12;
    chk("rst_ct_sready", ct_s.tready, 0);
    chk("rst_ct_mvalid", ct_m.tvalid, 0);
    chk("rst_ct_fill", ct_fill, 0);
    chk("rst_ct_pkt", ct_pkt, 0);
    chk("rst_sf_mvalid", sf_m.tvalid, 0);
    chk("rst_sf_ovf", sf_ovf, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("rel_ct_sready", ct_s.tready, 1);
    chk("rel_sf_sready", sf_s.tready, 1);

    // Cut-through single beat
    ct_m.tready = 1'b1;
    sf_m.tready = 1'b1;
    send(1'b0, 64'hA5, 1'b1);
    chk("ct1_mvalid", ct_m.tvalid, 1);
    chk("ct1_mdata", ct_m.tdata, 64'hA5);
    chk("ct1_fill", ct_fill, 1);
    @(posedge aclk);
    #1;
    chk("ct1_fill_after", ct_fill, 0);
    chk("ct1_mvalid_after", ct_m.tvalid, 0);

    // Fill to DEPTH, single pop
    ct_m.tready = 1'b0;
    for (int i = 0; i < 16; i++) send(1'b0, 64'h100 + 64'(i), (i == 15));
    chk("full_sready", ct_s.tready, 0);
    chk("full_fill", ct_fill, 16);
    chk("full_pkt", ct_pkt, 1);
    ct_m.tready = 1'b1;
    @(posedge aclk);
    #1;
    ct_m.tready = 1'b0;
    chk("full_pop_sready", ct_s.tready, 1);
    chk("full_pop_fill", ct_fill, 15);
    ct_m.tready = 1'b1;
    wait_empty(1'b0);
    chk("full_pkt_drained", ct_pkt, 0);

    // Store-and-forward 3-beat packet
    send(1'b1, 64'h200, 1'b0);
    chk("sf3_b1_mvalid", sf_m.tvalid, 0);
    chk("sf3_b1_pkt", sf_pkt, 0);
    send(1'b1, 64'h201, 1'b0);
    chk("sf3_b2_mvalid", sf_m.tvalid, 0);
    send(1'b1, 64'h202, 1'b1);
    chk("sf3_b3_mvalid", sf_m.tvalid, 1);
    chk("sf3_b3_pkt", sf_pkt, 1);
    wait_empty(1'b1);
    chk("sf3_pkt_done", sf_pkt, 0);

    // Store-and-forward oversize packet of 20 beats
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 64'h300 + 64'(i), (i == 19));
      if (i == 15) begin
        chk("ovs_fill16", sf_fill, 16);
        chk("ovs_mvalid_held", sf_m.tvalid, 0);
        chk("ovs_err_pre", sf_ovf, 0);
      end
      if (i == 16) chk("ovs_err_set", sf_ovf, 1);
    end
    wait_empty(1'b1);
    send(1'b1, 64'h400, 1'b0);
    chk("ovs_next_mvalid", sf_m.tvalid, 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("ovs_next_held", sf_m.tvalid, 0);
    chk("ovs_next_fill", sf_fill, 1);
    send(1'b1, 64'h401, 1'b1);
    chk("ovs_next_release", sf_m.tvalid, 1);
    wait_empty(1'b1);
    chk("ovs_err_sticky", sf_ovf, 1);

    // Steady push+pop at fill level 8 across pointer wrap
    ct_m.tready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 64'h1000 + 64'(i), (i % 5 == 4));
    chk("steady_fill_pre", ct_fill, 8);
    ct_m.tready = 1'b1;
    for (int i = 8; i < 108; i++) begin
      send(1'b0, 64'h1000 + 64'(i), (i % 5 == 4));
      chk("steady_fill", ct_fill, 8);
    end
    wait_empty(1'b0);

    // Reset in the middle of a packet
    ct_m.tready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 64'h2000 + 64'(i), 1'b0);
    chk("mid_fill_pre", ct_fill, 5);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_mvalid", ct_m.tvalid, 0);
    chk("mid_rst_sready", ct_s.tready, 0);
    chk("mid_rst_fill", ct_fill, 0);
    chk("mid_rst_pkt", ct_pkt, 0);
    chk("mid_rst_sf_ovf", sf_ovf, 0);
    exp_ct.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("mid_rel_sready", ct_s.tready, 1);
    chk("mid_rel_fill", ct_fill, 0);
    ct_m.tready = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b0, 64'h3000 + 64'(i), (i == 2));
    wait_empty(1'b0);
    chk("mid_pkt_final", ct_pkt, 0);

    repeat (2) @(posedge aclk);
    #1;
    chk("ct_queue_empty", exp_ct.size(), 0);
    chk("sf_queue_empty", exp_sf.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
